// File: rtl/cim_operand_loader_if.sv
// Operand stream and result handshake bundle for the CIM operand loader.
// The slave side is the loader; the master side feeds operands and accepts results.
interface cim_operand_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  cfg_reuse_wgt;
  logic                  r_valid;
  logic                  r_ready;
  logic [ACC_WIDTH-1:0]  r_data;

  modport slave (
    input  s_valid, s_data, s_last, cfg_reuse_wgt, r_ready,
    output s_ready, r_valid, r_data
  );

  modport master (
    output s_valid, s_data, s_last, cfg_reuse_wgt, r_ready,
    input  s_ready, r_valid, r_data
  );
endinterface

// File: rtl/cim_operand_loader.sv
// Collects byte-serial activation/weight frames into parallel lane vectors,
// kicks the CIM MAC array and hands its result back over a valid/ready port.
module cim_operand_loader #(
  parameter int MAC_COUNT  = 256,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  cim_operand_loader_if.slave             bus,
  output logic [MAC_COUNT*DATA_WIDTH-1:0] act_vec,
  output logic [MAC_COUNT*DATA_WIDTH-1:0] wgt_vec,
  output logic                            mac_start,
  input  logic                            mac_done,
  input  logic [ACC_WIDTH-1:0]            mac_result,
  output logic                            err_pulse,
  output logic [1:0]                      err_code
);

  localparam int CNT_W = (MAC_COUNT > 1) ? $clog2(MAC_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(MAC_COUNT - 1);

  localparam logic [1:0] ERR_EARLY_LAST = 2'b01;
  localparam logic [1:0] ERR_NO_LAST    = 2'b10;
  localparam logic [1:0] ERR_NO_WGT     = 2'b11;

  typedef enum logic [2:0] {
    S_ACT,
    S_WGT,
    S_START,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 reuse_reg, reuse_next;
  logic                 wgt_valid_reg, wgt_valid_next;
  logic [ACC_WIDTH-1:0] r_data_reg;
  logic                 err_pulse_reg;
  logic [1:0]           err_code_reg, err_code_next;
  logic                 err_fire;
  logic                 beat;
  logic                 act_we;
  logic                 wgt_we;
  logic                 reuse_now;

  assign bus.s_ready = !rst && (state_reg == S_ACT || state_reg == S_WGT ||
                                state_reg == S_DRAIN);
  assign beat        = bus.s_valid && bus.s_ready;
  assign bus.r_valid = (state_reg == S_OUT);
  assign bus.r_data  = r_data_reg;
  assign err_pulse   = err_pulse_reg;
  assign err_code    = err_code_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    reuse_next     = reuse_reg;
    wgt_valid_next = wgt_valid_reg;
    err_fire       = 1'b0;
    err_code_next  = err_code_reg;
    act_we         = 1'b0;
    wgt_we         = 1'b0;
    mac_start      = 1'b0;
    // The reuse flag is sampled on beat 0, so lane 0 must see the live input.
    reuse_now      = (cnt_reg == '0) ? bus.cfg_reuse_wgt : reuse_reg;

    case (state_reg)
      S_ACT: begin
        if (beat) begin
          act_we = 1'b1;
          if (cnt_reg == '0) begin
            reuse_next = bus.cfg_reuse_wgt;
          end
          if (cnt_reg == '0 && bus.cfg_reuse_wgt && !wgt_valid_reg) begin
            err_fire      = 1'b1;
            err_code_next = ERR_NO_WGT;
            cnt_next      = '0;
            state_next    = bus.s_last ? S_ACT : S_DRAIN;
          end else if (cnt_reg == LAST_LANE) begin
            cnt_next = '0;
            if (reuse_now) begin
              if (bus.s_last) begin
                state_next = S_START;
              end else begin
                err_fire      = 1'b1;
                err_code_next = ERR_NO_LAST;
                state_next    = S_DRAIN;
              end
            end else if (bus.s_last) begin
              err_fire      = 1'b1;
              err_code_next = ERR_EARLY_LAST;
              state_next    = S_ACT;
            end else begin
              wgt_valid_next = 1'b0;
              state_next     = S_WGT;
            end
          end else if (bus.s_last) begin
            err_fire      = 1'b1;
            err_code_next = ERR_EARLY_LAST;
            cnt_next      = '0;
            state_next    = S_ACT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      S_WGT: begin
        if (beat) begin
          wgt_we = 1'b1;
          if (cnt_reg == LAST_LANE) begin
            cnt_next = '0;
            if (bus.s_last) begin
              wgt_valid_next = 1'b1;
              state_next     = S_START;
            end else begin
              err_fire      = 1'b1;
              err_code_next = ERR_NO_LAST;
              state_next    = S_DRAIN;
            end
          end else if (bus.s_last) begin
            err_fire      = 1'b1;
            err_code_next = ERR_EARLY_LAST;
            cnt_next      = '0;
            state_next    = S_ACT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      S_START: begin
        mac_start  = 1'b1;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        if (mac_done) begin
          state_next = S_OUT;
        end
      end

      S_OUT: begin
        if (bus.r_ready) begin
          cnt_next   = '0;
          state_next = S_ACT;
        end
      end

      S_DRAIN: begin
        if (beat && bus.s_last) begin
          cnt_next   = '0;
          state_next = S_ACT;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = S_ACT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_ACT;
      cnt_reg       <= '0;
      reuse_reg     <= 1'b0;
      wgt_valid_reg <= 1'b0;
      r_data_reg    <= '0;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= 2'b00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      reuse_reg     <= reuse_next;
      wgt_valid_reg <= wgt_valid_next;
      err_pulse_reg <= err_fire;
      err_code_reg  <= err_code_next;
      if (state_reg == S_WAIT && mac_done) begin
        r_data_reg <= mac_result;
      end
    end
  end

  // One register per lane; the beat counter selects which lane a beat lands in.
  generate
    for (genvar gi = 0; gi < MAC_COUNT; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] act_lane_reg;
      logic [DATA_WIDTH-1:0] wgt_lane_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          act_lane_reg <= '0;
          wgt_lane_reg <= '0;
        end else begin
          if (act_we && cnt_reg == CNT_W'(gi)) begin
            act_lane_reg <= bus.s_data;
          end
          if (wgt_we && cnt_reg == CNT_W'(gi)) begin
            wgt_lane_reg <= bus.s_data;
          end
        end
      end

      assign act_vec[gi*DATA_WIDTH +: DATA_WIDTH] = act_lane_reg;
      assign wgt_vec[gi*DATA_WIDTH +: DATA_WIDTH] = wgt_lane_reg;
    end
  endgenerate

endmodule

// File: doc/cim_operand_loader.md
Name: cim_operand_loader

Overview:
- Feeds the CIM MAC array from a byte-serial valid/ready stream.
- Each frame carries MAC_COUNT activations and then MAC_COUNT weights. The block assembles them into flattened parallel vectors and issues a one-cycle start.
- It captures the array's result on done and returns it on a valid/ready result port.
- Optional weight-reuse frames carry activations only.

Parameters:
MAC_COUNT, 256, number of lanes (beats per vector)
DATA_WIDTH, 8, signed operand width
ACC_WIDTH, 32, result width

Ports:
clk  in  1  clock
rst  in  1  reset (one clock; reset is synchronous and active-high)
s_valid  in  1  stream beat valid
s_ready  out  1  stream beat accepted when s_valid&s_ready
s_data  in  DATA_WIDTH  signed operand byte
s_last  in  1  marks final beat of frame
cfg_reuse_wgt  in  1  sampled on first beat of frame: 1 = activation-only frame, keep stored weights
act_vec  out  MAC_COUNT*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
wgt_vec  out  MAC_COUNT*DATA_WIDTH  same lane mapping
mac_start  out  1  one-cycle start to array
mac_done  in  1  array done pulse
mac_result  in  ACC_WIDTH  array result, valid with mac_done
r_valid  out  1  result valid
r_ready  in  1  result accepted when r_valid&r_ready
r_data  out  ACC_WIDTH  captured result
err_pulse  out  1  one-cycle frame error strobe
err_code  out  2  01 early s_last, 10 missing s_last, 11 reuse with no stored weights; holds until next error

Behaviour:
- Reset: state S_ACT, beat counter 0, wgt_valid 0, act_vec/wgt_vec 0.
- Reset values of outputs: s_ready 0 during reset, mac_start 0, r_valid 0, r_data 0, err_pulse 0, err_code 00.
- Reset mid-operation aborts any frame or pending result without producing output.
- States:
  - S_ACT: s_ready=1. Beat k writes act lane k.
    - On beat 0, latch reuse = cfg_reuse_wgt.
    - If reuse and !wgt_valid: err 11, go S_DRAIN. If that beat also has s_last, go S_ACT instead.
    - After lane MAC_COUNT-1: go S_START if reuse, else S_WGT.
  - S_WGT: s_ready=1. Beat k writes wgt lane k. Entering S_WGT clears wgt_valid. After lane MAC_COUNT-1, set wgt_valid and go S_START.
  - S_START: s_ready=0, mac_start=1 for exactly this cycle, go S_WAIT.
  - S_WAIT: s_ready=0. On mac_done, r_data<=mac_result, go S_OUT.
  - S_OUT: r_valid=1, r_data stable. On r_ready, go S_ACT and reset the counter.
  - S_DRAIN: s_ready=1, discard beats. On a beat with s_last, go S_ACT.
- Framing:
  - s_last must accompany exactly the final beat: beat MAC_COUNT-1 of the activations for reuse frames, beat MAC_COUNT-1 of the weights otherwise.
  - s_last on an earlier beat: err 01, frame dropped, no mac_start, go S_ACT.
  - Final beat without s_last: err 10, no mac_start, go S_DRAIN.
  - Any error during S_WGT leaves wgt_valid=0.
- Timing: last beat accepted at cycle T, then mac_start at T+1, mac_done from the array at T+2, r_valid at T+3. Zero bubble between beats while s_valid is held.
- act_vec/wgt_vec are written only on accepted beats in S_ACT/S_WGT. They are stable from S_START through S_OUT.
- mac_done outside S_WAIT is ignored.
- err_pulse fires the cycle after the offending beat.
- Counter width is clog2(MAC_COUNT). No wrap beyond MAC_COUNT-1 is possible, because state changes at the last lane.

Test Plan:
- Bench uses MAC_COUNT=4 with a behavioural array model. Full frame acts 1,2,3,4, wgts 5,6,7,8, s_last on beat 8 -> mac_start 1 cycle after beat 8, r_valid 2 cycles later, r_data=70.
- Then a reuse frame, acts -1,-1,-1,-1 with cfg_reuse_wgt=1 and s_last on beat 4 -> r_data=-26, wgt_vec unchanged.
- s_last on beat 2 of a full frame -> err_pulse, err_code=01, no mac_start. The next valid frame still gives the correct result.
- Reuse frame right after reset -> err_code=11, 4 beats drained, no mac_start, wgt_valid remains 0.
- r_ready held low 10 cycles in S_OUT -> r_valid stays 1, r_data stable, s_ready=0. On r_ready the block returns to S_ACT.
- Weight beats missing s_last (s_last on beat 10) -> err_code=10 at beat 8, drain through beat 10. A following reuse frame -> err_code=11.
- rst asserted in S_WAIT -> all outputs 0; a later mac_done pulse is ignored, and the next frame completes normally.
